// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO push port between NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add stall_cnt, a saturating count of full-stalled burst cycles.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_wdata,
    output logic [1:0]                grant_id,
    output logic                      busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [7:0]                stall_cnt
`endif
);
    typedef enum logic {IDLE, BURST} state_t;
    localparam logic [1:0] LAST_ID   = 2'(NUM_REQ - 1);
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       any_req, start, gnt_valid, burst_done;

    // first valid requester at or above rr_ptr, wrapping around
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < NUM_REQ; i++)
                if (!any_req && req_valid[i] && i == (int'(rr_ptr_q) + k) % NUM_REQ) begin
                    any_req = 1'b1;
                    pick    = 2'(i);
                end
    end

    always_comb begin
        gnt_valid  = 1'b0;
        fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (2'(i) == grant_id_q) begin
                gnt_valid  = req_valid[i];
                fifo_wdata = req_data[i*DATA_W +: DATA_W];
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        start      = (state_q == IDLE) && ena && any_req;
        burst_done = (fifo_push && beat_cnt_q == LAST_BEAT) || (busy && !gnt_valid);
        state_d    = (state_q == IDLE) ? (start ? BURST : IDLE) : (burst_done ? IDLE : BURST);
    end

    always_comb begin
        busy      = (state_q == BURST);
        fifo_push = busy && gnt_valid && !fifo_full;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = busy && !fifo_full && 2'(i) == grant_id_q;
    end

    always_comb begin
        grant_id_d = start ? pick : grant_id_q;
        beat_cnt_d = start ? 4'd0 : fifo_push ? beat_cnt_q + 4'd1 : beat_cnt_q;
        rr_ptr_d   = burst_done ? ((grant_id_q == LAST_ID) ? 2'd0 : grant_id_q + 2'd1) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end

    assign grant_id = grant_id_q;

`ifdef FIFO_ARB_STATS_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;

    always_comb
        stall_cnt_d = (busy && gnt_valid && fifo_full && stall_cnt_q != 8'hFF) ? stall_cnt_q + 8'd1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scenario tasks plus randomized traffic checked against a cycle-level reference model.
module tb_fifo_write_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0, full = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ready, grant_id;
    logic        fifo_push, busy;
    logic [7:0]  fifo_wdata;
    logic [2:0]  b_valid = '0, b_ready;
    logic [23:0] b_data = '0;
    logic        b_push, b_busy;
    logic [7:0]  b_wdata;
    logic [1:0]  b_gid;
`ifdef FIFO_ARB_STATS_EN
    logic [7:0]  stall_cnt, b_stall;
`endif

    int errors = 0, checks = 0, cyc = 0, generated = 0;
    logic [7:0] pq [2][$];
    logic [7:0] fifo_log [$];
    logic [1:0] pv = '0;
    bit rand_mode = 0;
    bit m_busy;
    int m_gid, m_rr, m_beat, m_stall;
    localparam int MB = 4;

    fifo_write_arbiter #(.NUM_REQ(2), .DATA_W(8), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(full), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
        .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    fifo_write_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_BURST(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .fifo_full(1'b0), .fifo_push(b_push), .fifo_wdata(b_wdata),
        .grant_id(b_gid), .busy(b_busy)
`ifdef FIFO_ARB_STATS_EN
        , .stall_cnt(b_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_gid = 0; m_rr = 0; m_beat = 0; m_stall = 0;
    endtask

    function automatic int first_from(int rr, logic [1:0] v);
        for (int k = 0; k < 2; k++)
            if (v[(rr + k) % 2]) return (rr + k) % 2;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 2; i++)
            if (!pv[i] && pq[i].size() != 0 && (!rand_mode || $urandom_range(3) != 0)) pv[i] = 1'b1;
        req_valid = pv;
        for (int i = 0; i < 2; i++)
            req_data[i*8 +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    endtask

    task automatic step();
        logic [1:0] v, e_ready;
        bit e_push;
        int f;
        drive();
        v = pv;
        e_push = m_busy && v[m_gid] && !full;
        e_ready = (m_busy && !full) ? 2'(1 << m_gid) : 2'b00;
        @(negedge clk);
        checks++; if (busy !== m_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
        checks++; if (fifo_push !== e_push) begin errors++; $display("FAIL push cyc=%0d got=%b exp=%b", cyc, fifo_push, e_push); end
        checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
        if (m_busy) begin
            checks++; if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL grant cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_gid); end
        end
        if (e_push) begin
            checks++; if (fifo_wdata !== pq[m_gid][0]) begin errors++; $display("FAIL wdata cyc=%0d got=%h exp=%h", cyc, fifo_wdata, pq[m_gid][0]); end
        end
`ifdef FIFO_ARB_STATS_EN
        checks++; if (stall_cnt !== 8'(m_stall)) begin errors++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall); end
`endif
        if (fifo_push) fifo_log.push_back(fifo_wdata);
        if (e_push) begin void'(pq[m_gid].pop_front()); pv[m_gid] = 1'b0; end
        if (m_busy) begin
            if (v[m_gid] && full && m_stall < 255) m_stall++;
            if (e_push) m_beat++;
            if ((e_push && m_beat == MB) || !v[m_gid]) begin m_busy = 0; m_rr = (m_gid + 1) % 2; end
        end else if (ena) begin
            f = first_from(m_rr, v);
            if (f >= 0) begin m_busy = 1; m_gid = f; m_beat = 0; end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((pq[0].size() != 0 || pq[1].size() != 0 || m_busy) && n < max) begin step(); n++; end
        checks++; if (n >= max) begin errors++; $display("FAIL drain_timeout got=%0d exp<%0d", n, max); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL rst_push got=%b exp=0", fifo_push); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got=%0d exp=0", grant_id); end
        checks++; if ({b_busy, b_push, b_ready} !== 5'b0) begin errors++; $display("FAIL rst_b got=%b exp=0", {b_busy, b_push, b_ready}); end
`ifdef FIFO_ARB_STATS_EN
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        ena = 1'b1;
    endtask

    task automatic test_rotate3();
        int g;
        b_data = 24'h121110;
        b_valid = 3'b111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g = (c / 2) % 3;
            checks++; if (b_busy !== c[0]) begin errors++; $display("FAIL rot_busy c=%0d got=%b exp=%b", c, b_busy, c[0]); end
            checks++; if (b_push !== c[0]) begin errors++; $display("FAIL rot_push c=%0d got=%b exp=%b", c, b_push, c[0]); end
            if (c[0]) begin
                checks++; if (b_gid !== 2'(g)) begin errors++; $display("FAIL rot_grant c=%0d got=%0d exp=%0d", c, b_gid, g); end
                checks++; if (b_wdata !== 8'(8'h10 + g)) begin errors++; $display("FAIL rot_wdata c=%0d got=%h exp=%h", c, b_wdata, 8'h10 + g); end
                checks++; if (b_ready !== 3'(1 << g)) begin errors++; $display("FAIL rot_ready c=%0d got=%b exp=%b", c, b_ready, 3'(1 << g)); end
            end
            @(posedge clk); #1;
        end
        b_valid = '0;
    endtask

    task automatic test_rr_burst();
        logic [7:0] e;
        fifo_log.delete();
        for (int k = 0; k < 4; k++) begin pq[0].push_back(8'(8'hA0 + k)); pq[1].push_back(8'(8'hB0 + k)); end
        drain(40);
        checks++; if (fifo_log.size() != 8) begin errors++; $display("FAIL rr_count got=%0d exp=8", fifo_log.size()); end
        for (int k = 0; k < 8 && k < fifo_log.size(); k++) begin
            e = (k < 4) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 4);
            checks++; if (fifo_log[k] !== e) begin errors++; $display("FAIL rr_order k=%0d got=%h exp=%h", k, fifo_log[k], e); end
        end
    endtask

    task automatic test_drop();
        fifo_log.delete();
        pq[1].push_back(8'hC0); pq[1].push_back(8'hC1);
        drain(20);
        checks++; if (fifo_log.size() != 2) begin errors++; $display("FAIL drop_count got=%0d exp=2", fifo_log.size()); end
        pq[0].push_back(8'hD0); pq[0].push_back(8'hD1);
        pq[1].push_back(8'hE0); pq[1].push_back(8'hE1);
        drain(30);
        checks++; if (fifo_log.size() != 6) begin errors++; $display("FAIL drop_total got=%0d exp=6", fifo_log.size()); end
        else begin
            checks++; if (fifo_log[2] !== 8'hD0) begin errors++; $display("FAIL drop_next got=%h exp=d0", fifo_log[2]); end
        end
    endtask

    task automatic test_stall();
        int s0 = m_stall;
        fifo_log.delete();
        for (int k = 0; k < 4; k++) pq[0].push_back(8'(8'hF0 + k));
        for (int c = 0; c < 12; c++) begin full = (c >= 2 && c <= 4); step(); end
        full = 1'b0;
        checks++; if (fifo_log.size() != 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", fifo_log.size()); end
        for (int k = 0; k < 4 && k < fifo_log.size(); k++) begin
            checks++; if (fifo_log[k] !== 8'(8'hF0 + k)) begin errors++; $display("FAIL stall_order k=%0d got=%h exp=%h", k, fifo_log[k], 8'hF0 + k); end
        end
`ifdef FIFO_ARB_STATS_EN
        checks++; if (stall_cnt !== 8'(s0 + 3)) begin errors++; $display("FAIL stall_stat got=%0d exp=%0d", stall_cnt, s0 + 3); end
`else
        s0 = 0;
`endif
    endtask

    task automatic test_ena();
        fifo_log.delete();
        ena = 1'b0;
        for (int k = 0; k < 4; k++) pq[0].push_back(8'(8'h50 + k));
        repeat (5) step();
        checks++; if (fifo_log.size() != 0) begin errors++; $display("FAIL ena_block got=%0d exp=0", fifo_log.size()); end
        ena = 1'b1;
        step();
        ena = 1'b0;
        repeat (8) step();
        checks++; if (fifo_log.size() != 4) begin errors++; $display("FAIL ena_burst got=%0d exp=4", fifo_log.size()); end
        for (int k = 0; k < 4; k++) pq[0].push_back(8'(8'h60 + k));
        repeat (6) step();
        checks++; if (fifo_log.size() != 4 || busy !== 1'b0) begin errors++; $display("FAIL ena_nogrant got=%0d/%b exp=4/0", fifo_log.size(), busy); end
        ena = 1'b1;
        drain(30);
        checks++; if (fifo_log.size() != 8) begin errors++; $display("FAIL ena_resume got=%0d exp=8", fifo_log.size()); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        fifo_log.delete();
        for (int k = 0; k < 4; k++) begin pq[0].push_back(8'(8'h70 + k)); pq[1].push_back(8'(8'h80 + k)); end
        while (fifo_log.size() < 2 && n < 20) begin step(); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL arst_wait got=%0d exp<20", n); end
        drive();
        #2;
        checks++; if (busy !== 1'b1 || fifo_push !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b%b exp=11", busy, fifo_push); end
        rst_n = 1'b0;
        #1;
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL arst_push got=%b exp=0", fifo_push); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL arst_ready got=%b exp=00", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
        pq[0].delete(); pq[1].delete(); pv = '0; req_valid = '0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fifo_log.delete();
        for (int k = 0; k < 4; k++) begin pq[0].push_back(8'(8'h90 + k)); pq[1].push_back(8'(8'hC8 + k)); end
        drain(40);
        checks++; if (fifo_log.size() != 8) begin errors++; $display("FAIL arst_count got=%0d exp=8", fifo_log.size()); end
        else begin
            checks++; if (fifo_log[0] !== 8'h90) begin errors++; $display("FAIL arst_first got=%h exp=90", fifo_log[0]); end
        end
    endtask

    task automatic test_random();
        int p;
        fifo_log.delete();
        generated = 0;
        rand_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(2) == 0) begin
                p = $urandom_range(1);
                if (pq[p].size() < 8) begin pq[p].push_back(8'($urandom)); generated++; end
            end
            ena = ($urandom_range(9) != 0);
            full = ($urandom_range(3) == 0);
            step();
        end
        ena = 1'b1; full = 1'b0;
        drain(200);
        rand_mode = 0;
        checks++; if (fifo_log.size() != generated) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", fifo_log.size(), generated); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotate3();
        test_rr_burst();
        test_drop();
        test_stall();
        test_ena();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single push port of the team's FIFO between NUM_REQ producers, using valid/ready handshakes. It sits between the producer-side pin/decoder logic and the FIFO write interface inside the tt_um top. A grant is held for bursts of up to MAX_BURST words so consecutive words from one producer stay contiguous in the FIFO. FIFO backpressure (full) is propagated to the granted producer only.

Parameters:
NUM_REQ, 2, number of producers (2..4)
DATA_W, 8, FIFO word width
MAX_BURST, 4, max words pushed per grant (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low blocks new grants
req_valid  input  NUM_REQ  per-producer word valid
req_data  input  NUM_REQ*DATA_W  per-producer word; producer i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-producer accept strobe
fifo_full  input  1  FIFO full flag
fifo_push  output  1  FIFO write strobe
fifo_wdata  output  DATA_W  FIFO write data
grant_id  output  2  index of current grant holder (valid while busy=1)
busy  output  1  high in BURST state

Behaviour:
- Reset is asynchronous and active-low on rst_n. All state is clocked on clk.
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0, req_ready=0, fifo_push=0. fifo_wdata follows the granted requester's data combinationally; it is don't-care when fifo_push=0.
- States: IDLE, BURST.
- IDLE: if ena=1 and any req_valid is set, the arbiter selects the first set bit searching from rr_ptr upward modulo NUM_REQ. It latches grant_id, clears beat_cnt and goes to BURST next cycle. No push happens in IDLE, so arbitration latency is 1 cycle.
- BURST: req_ready[grant_id] = !fifo_full. All other req_ready bits are 0.
- BURST: fifo_push = req_valid[grant_id] & !fifo_full. fifo_wdata = req_data slice of grant_id.
- Each push increments beat_cnt.
- BURST exits to IDLE when either:
  - a push occurs with beat_cnt==MAX_BURST-1, or
  - req_valid[grant_id]=0 in a cycle with no push.
- On exit, rr_ptr = (grant_id+1) mod NUM_REQ.
- fifo_full=1 stalls the burst: no push, beat_cnt holds, grant is held, and no timeout applies.
- ena falling during BURST does not abort the burst. It only blocks the next grant from IDLE.
- A simultaneous request from all producers is served in rotation starting at rr_ptr. No producer waits more than NUM_REQ-1 bursts.
- A requester's valid must stay high until ready. A valid drop mid-burst ends the burst, and no data is lost.
- Reset asserted mid-burst returns immediately to the reset values. No partial push is generated.

Optional Feature:
Macro FIFO_ARB_STATS_EN.
- Defined: adds output stall_cnt[7:0]. It increments, saturating at 255, on each BURST cycle where req_valid[grant_id]=1 and fifo_full=1. It resets to 0 on rst_n.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then req_valid=2'b11 and fifo_full=0 with data A0..A3 / B0..B3 -> grant_id=0 on cycle 1, pushes A0..A3 on cycles 1-4, then IDLE for 1 cycle, grant_id=1, pushes B0..B3. FIFO order is A0..A3, B0..B3.
- Only req 1 valid with 2 words, then drops valid -> 2 pushes, busy falls, rr_ptr=0. Then req 0 and req 1 both valid -> req 0 granted first.
- Mid-burst fifo_full=1 for 3 cycles -> fifo_push=0 and req_ready=0 for those cycles, beat_cnt held, burst resumes to a total of 4 words. With FIFO_ARB_STATS_EN, stall_cnt=3.
- ena=0 with req_valid=2'b01 -> busy stays 0 and no push. Set ena=1 -> grant next cycle. Drop ena mid-burst -> burst completes all 4 words, then no new grant.
- Assert rst_n=0 asynchronously mid-burst after 2 pushes -> fifo_push, req_ready and busy go 0 immediately. After release, the arbiter starts from rr_ptr=0.
- MAX_BURST=1, NUM_REQ=3, all valid -> grants rotate 0,1,2,0 with one push each and an idle cycle between grants.
